// File: rtl/mem_port_if.sv
// mem_port_if: fetch/data requester handshakes and the shared memory port of mem_port_arbiter
interface mem_port_if #(
    parameter int XLEN = 32
);
    logic            if_req_i;
    logic [XLEN-1:0] if_addr_i;
    logic            if_gnt_o;
    logic            if_rvalid_o;
    logic [XLEN-1:0] if_rdata_o;
    logic            d_req_i;
    logic            d_we_i;
    logic [XLEN-1:0] d_addr_i;
    logic [XLEN-1:0] d_wdata_i;
    logic            d_gnt_o;
    logic            d_rvalid_o;
    logic [XLEN-1:0] d_rdata_o;
    logic            mem_req_o;
    logic            mem_we_o;
    logic [XLEN-1:0] mem_addr_o;
    logic [XLEN-1:0] mem_wdata_o;
    logic            mem_ack_i;
    logic [XLEN-1:0] mem_rdata_i;

    modport slave (
        input  if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, mem_ack_i, mem_rdata_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, mem_ack_i, mem_rdata_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: alternating-priority fetch/data arbiter for one shared memory port with ack timeout
module mem_port_arbiter #(
    parameter int XLEN     = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic      clk_i,
    input  logic      rst_i,
    mem_port_if.slave bus,
    output logic      err_o
);
    typedef enum logic [1:0] {IDLE, SERVE_IF, SERVE_D} state_t;
    localparam logic [7:0]      WAIT_LIMIT = 8'(MAX_WAIT);
    localparam logic [XLEN-1:0] ZERO       = '0;
    state_t     state_q, state_d;
    logic       last_d_q;
    logic [7:0] wait_q;
    logic       idle, done, timeout;

    always_comb begin
        idle          = state_q == IDLE;
        bus.mem_req_o = !idle;
        bus.if_gnt_o  = idle && !rst_i && bus.if_req_i && (!bus.d_req_i || last_d_q);
        bus.d_gnt_o   = idle && !rst_i && bus.d_req_i && (!bus.if_req_i || !last_d_q);
        // an ack on the limit cycle wins over the timeout
        done          = !idle && bus.mem_ack_i;
        timeout       = !idle && !bus.mem_ack_i && wait_q == WAIT_LIMIT;
        state_d       = bus.d_gnt_o ? SERVE_D : bus.if_gnt_o ? SERVE_IF : (done || timeout) ? IDLE : state_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= IDLE;
            last_d_q        <= 1'b0;
            wait_q          <= 8'd0;
            err_o           <= 1'b0;
            bus.mem_we_o    <= 1'b0;
            bus.mem_addr_o  <= ZERO;
            bus.mem_wdata_o <= ZERO;
            bus.if_rvalid_o <= 1'b0;
            bus.d_rvalid_o  <= 1'b0;
            bus.if_rdata_o  <= ZERO;
            bus.d_rdata_o   <= ZERO;
        end else begin
            state_q         <= state_d;
            wait_q          <= (!idle && !done && !timeout) ? wait_q + 8'd1 : 8'd0;
            bus.if_rvalid_o <= state_q == SERVE_IF && (done || timeout);
            bus.d_rvalid_o  <= state_q == SERVE_D && (done || timeout);
            if (bus.d_gnt_o || bus.if_gnt_o) begin
                last_d_q        <= bus.d_gnt_o;
                bus.mem_we_o    <= bus.d_gnt_o && bus.d_we_i;
                bus.mem_addr_o  <= bus.d_gnt_o ? bus.d_addr_i : bus.if_addr_i;
                bus.mem_wdata_o <= bus.d_gnt_o ? bus.d_wdata_i : ZERO;
            end
            if (state_q == SERVE_IF && (done || timeout))
                bus.if_rdata_o <= done ? bus.mem_rdata_i : ZERO;
            if (state_q == SERVE_D && (done || timeout))
                bus.d_rdata_o <= (done && !bus.mem_we_o) ? bus.mem_rdata_i : ZERO;
            if (timeout)
                err_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter against a transaction-level model
module tb_mem_port_arbiter;
    localparam int XLEN     = 32;
    localparam int MAX_WAIT = 15;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            err_o;
    int              n_cmp = 0;
    int              n_err = 0;
    logic            m_last_d, m_err;
    logic [XLEN-1:0] m_if_rdata, m_d_rdata;
    logic [3:0]      order;
    logic [1:0]      pat;
    int              k;

    mem_port_if #(.XLEN(XLEN)) bus ();

    mem_port_arbiter #(.XLEN(XLEN), .MAX_WAIT(MAX_WAIT)) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus  (bus),
        .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_i         = 1'b1;
        bus.if_req_i  = 1'b1;
        bus.d_req_i   = 1'b1;
        bus.mem_ack_i = 1'b0;
        #1;
        chk("gnt_in_reset", {bus.if_gnt_o, bus.d_gnt_o}, 2'b00);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        chk("gnt_in_reset2", {bus.if_gnt_o, bus.d_gnt_o}, 2'b00);
        chk("rst_mem_req", bus.mem_req_o, 0);
        chk("rst_mem_we", bus.mem_we_o, 0);
        chk("rst_mem_addr", bus.mem_addr_o, 0);
        chk("rst_mem_wdata", bus.mem_wdata_o, 0);
        chk("rst_rvalid", {bus.if_rvalid_o, bus.d_rvalid_o}, 2'b00);
        chk("rst_if_rdata", bus.if_rdata_o, 0);
        chk("rst_d_rdata", bus.d_rdata_o, 0);
        chk("rst_err", err_o, 0);
        rst_i      = 1'b0;
        m_last_d   = 1'b0;
        m_err      = 1'b0;
        m_if_rdata = '0;
        m_d_rdata  = '0;
    endtask

    // One transaction from the IDLE cycle it is requested in up to its rvalid cycle; the ack comes
    // k cycles after mem_req_o rises, and k beyond MAX_WAIT means the memory never answers.
    task automatic txn(input logic rif, input logic rd, input logic we, input logic [XLEN-1:0] ia,
                       input logic [XLEN-1:0] da, input logic [XLEN-1:0] wd, input logic [XLEN-1:0] rdv,
                       input int ack_at);
        logic            win_d, tmo, e_we;
        logic [XLEN-1:0] e_addr, e_wdata, e_rdata;
        int              i;
        win_d   = rd && (!rif || !m_last_d);
        tmo     = ack_at > MAX_WAIT;
        e_addr  = win_d ? da : ia;
        e_we    = win_d && we;
        e_wdata = win_d ? wd : '0;
        e_rdata = (tmo || e_we) ? '0 : rdv;
        bus.if_req_i  = rif;
        bus.d_req_i   = rd;
        bus.d_we_i    = we;
        bus.if_addr_i = ia;
        bus.d_addr_i  = da;
        bus.d_wdata_i = wd;
        bus.mem_ack_i = 1'b0;
        #1;
        chk("if_gnt", bus.if_gnt_o, !win_d);
        chk("d_gnt", bus.d_gnt_o, win_d);
        order    = {order[2:0], win_d};
        m_last_d = win_d;
        @(posedge clk_i); #1;
        i = 0;
        forever begin
            chk("mem_req", bus.mem_req_o, 1);
            chk("mem_addr", bus.mem_addr_o, e_addr);
            chk("mem_we", bus.mem_we_o, e_we);
            chk("mem_wdata", bus.mem_wdata_o, e_wdata);
            chk("gnt_serve", {bus.if_gnt_o, bus.d_gnt_o}, 2'b00);
            chk("rvalid_serve", {bus.if_rvalid_o, bus.d_rvalid_o}, 2'b00);
            chk("if_rdata_hold", bus.if_rdata_o, m_if_rdata);
            chk("d_rdata_hold", bus.d_rdata_o, m_d_rdata);
            bus.mem_ack_i   = (i == ack_at);
            bus.mem_rdata_i = (i == ack_at) ? rdv : $urandom;
            bus.if_req_i    = 1'($urandom);
            bus.d_req_i     = 1'($urandom);
            bus.d_we_i      = 1'($urandom);
            bus.if_addr_i   = $urandom;
            bus.d_addr_i    = $urandom;
            bus.d_wdata_i   = $urandom;
            @(posedge clk_i); #1;
            if (i == ack_at || i == MAX_WAIT) break;
            i++;
        end
        bus.mem_ack_i = 1'b0;
        bus.if_req_i  = 1'b0;
        bus.d_req_i   = 1'b0;
        if (win_d) m_d_rdata = e_rdata;
        else m_if_rdata = e_rdata;
        m_err = m_err || tmo;
        chk("mem_req_done", bus.mem_req_o, 0);
        chk("if_rvalid", bus.if_rvalid_o, !win_d);
        chk("d_rvalid", bus.d_rvalid_o, win_d);
        chk("if_rdata", bus.if_rdata_o, m_if_rdata);
        chk("d_rdata", bus.d_rdata_o, m_d_rdata);
        chk("err", err_o, m_err);
    endtask

    initial begin
        bus.if_req_i    = 1'b0;
        bus.if_addr_i   = '0;
        bus.d_req_i     = 1'b0;
        bus.d_we_i      = 1'b0;
        bus.d_addr_i    = '0;
        bus.d_wdata_i   = '0;
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = '0;
        rst_i           = 1'b1;
        order           = '0;
        do_reset();
        // single fetch, ack two cycles after mem_req_o rises
        txn(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 32'h00500093, 2);
        // contention from reset with immediate acks
        do_reset();
        order = '0;
        repeat (4) txn(1'b1, 1'b1, 1'($urandom), $urandom, $urandom, $urandom, $urandom, 0);
        chk("grant_order", order, 4'b1010);
        // store with toggling inputs
        txn(1'b0, 1'b1, 1'b1, $urandom, 32'h100, 32'hDEADBEEF, $urandom, 3);
        // timeout, then a stray ack in IDLE
        txn(1'b1, 1'b0, 1'b0, 32'h200, 32'h0, 32'h0, 32'h12345678, 100);
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = 32'hBAD00000;
        @(posedge clk_i); #1;
        bus.mem_ack_i = 1'b0;
        chk("stray_ack_req", bus.mem_req_o, 0);
        chk("stray_ack_rvalid", {bus.if_rvalid_o, bus.d_rvalid_o}, 2'b00);
        chk("stray_ack_err", err_o, 1);
        chk("stray_ack_if_rdata", bus.if_rdata_o, m_if_rdata);
        // arbitration continues with err_o stuck
        txn(1'b1, 1'b1, 1'b0, $urandom, $urandom, $urandom, 32'h0BADF00D, 1);
        // ack on the limit cycle
        do_reset();
        txn(1'b1, 1'b0, 1'b0, 32'h300, 32'h0, 32'h0, 32'hCAFEF00D, MAX_WAIT);
        // reset three cycles into SERVE_D
        bus.d_req_i   = 1'b1;
        bus.d_we_i    = 1'b0;
        bus.d_addr_i  = 32'h400;
        bus.if_req_i  = 1'b0;
        bus.mem_ack_i = 1'b0;
        #1;
        chk("mid_rst_gnt", bus.d_gnt_o, 1);
        @(posedge clk_i); #1;
        bus.d_req_i = 1'b0;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        chk("mid_rst_busy", bus.mem_req_o, 1);
        rst_i        = 1'b1;
        bus.if_req_i = 1'b1;
        bus.d_req_i  = 1'b1;
        #1;
        chk("mid_rst_gnt_off", {bus.if_gnt_o, bus.d_gnt_o}, 2'b00);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        chk("mid_rst_req", bus.mem_req_o, 0);
        chk("mid_rst_rvalid", bus.d_rvalid_o, 0);
        chk("mid_rst_err", err_o, 0);
        m_last_d   = 1'b0;
        m_err      = 1'b0;
        m_if_rdata = '0;
        m_d_rdata  = '0;
        txn(1'b1, 1'b1, 1'b0, $urandom, $urandom, $urandom, $urandom, 1);
        chk("mid_rst_next_d", order[0], 1);
        // randomized traffic
        repeat (40) begin
            pat = 2'($urandom_range(1, 3));
            k   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(14, 17)) : int'($urandom_range(0, 3));
            txn(pat[0], pat[1], 1'($urandom), $urandom, $urandom, $urandom, $urandom, k);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
